pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller that owns the fetch program counter. Each cycle it picks the next PC from four sources: trap, branch/jump redirect, halt request, or sequential PC+4.
- Presents the PC to the fetch stage over a valid/ready handshake.
- Enforces the instruction-memory bound and a halted state.
- Sits between execute/writeback (the redirect and trap sources) and the instruction-fetch stage.

Parameters:
IMEM_WORDS, 128, instruction memory depth in 32-bit words; LAST_PC = (IMEM_WORDS-1)*4
RESET_PC, 32'h0000_0000, PC issued after reset and after resume
TRAP_PC, 32'h0000_0100, PC issued on trap or bad redirect target; must be < IMEM_WORDS*4 and word aligned
CNT_W, 16, width of redirect counter

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
o_valid  output  1  o_pc is a valid fetch address
o_pc  output  32  fetch PC
i_ready  input  1  fetch stage accepts o_pc this cycle
i_redirect_valid  input  1  taken branch/jump from execute
i_redirect_pc  input  32  redirect target
i_trap  input  1  exception; highest priority
i_halt_req  input  1  halt request (ecall/ebreak)
i_resume  input  1  leave HALTED
o_halted  output  1  sequencer in HALTED
o_bad_target  output  1  one-cycle pulse: redirect target misaligned or out of range
o_redirect_cnt  output  CNT_W  saturating count of applied redirects and traps

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values while rst is high:
  - State = RUN, o_valid = 1, o_pc = RESET_PC.
  - o_halted = 0, o_bad_target = 0, o_redirect_cnt = 0.
  - rst overrides every other input, including mid-stall and in HALTED.
- States: RUN and HALTED. All outputs are registered; every decision takes effect on the next posedge (1-cycle latency).
- RUN priority, highest first, evaluated every cycle regardless of i_ready:
  1. i_trap: o_pc <= TRAP_PC, o_valid <= 1, counter += 1. The offered PC is dropped.
  2. i_redirect_valid with a good target (bits[1:0] == 0 and target < IMEM_WORDS*4): o_pc <= i_redirect_pc, o_valid <= 1, counter += 1. The offered PC is dropped.
  3. i_redirect_valid with a bad target: o_pc <= TRAP_PC, o_valid <= 1, o_bad_target <= 1 for exactly one cycle, counter += 1.
  4. i_halt_req: go to HALTED, o_valid <= 0, o_pc holds.
  5. Handshake (o_valid & i_ready):
     - o_pc == LAST_PC: go to HALTED, o_valid <= 0, o_pc holds LAST_PC.
     - otherwise: o_pc <= o_pc + 4, o_valid <= 1.
  6. Else (stall, !i_ready): o_pc and o_valid hold. o_pc must be stable for as long as o_valid & !i_ready.
- HALTED:
  - o_valid = 0, o_halted = 1, o_pc holds the last value.
  - i_trap, i_redirect_valid and i_halt_req are ignored; no counter change and no o_bad_target.
  - i_resume: go to RUN next cycle with o_pc = RESET_PC, o_valid = 1, o_halted = 0.
  - i_resume is ignored in RUN.
- Simultaneous events:
  - Trap and redirect in the same cycle: trap wins and counter increments once.
  - Redirect and halt_req: redirect wins and halt_req is dropped (not latched).
  - Redirect to LAST_PC is legal; LAST_PC is issued and, once accepted, the sequencer halts.
- Counter: increments by exactly 1 per applied trap/redirect and saturates at all-ones (no wrap).
- Arithmetic: PC+4 is 32-bit unsigned. Wrap is unreachable because of the LAST_PC bound.
- Bounds check is unsigned compare against IMEM_WORDS*4 computed at 32 bits.

Test Plan:
- Reset, then i_ready = 1 constant, no events -> o_pc goes 0, 4, 8, … 0x1FC. After 0x1FC is accepted, o_valid = 0 and o_halted = 1 with o_pc = 0x1FC held; 128 valid handshakes total.
- Stall: i_ready = 0 for 5 cycles while o_pc = 0x10 -> o_pc = 0x10 and o_valid = 1 stable all 5 cycles. i_ready = 1 -> next o_pc = 0x14.
- Redirect to 0x40 during a stall at 0x08 -> next cycle o_pc = 0x40, o_valid = 1, o_redirect_cnt = 1. With i_trap asserted in the same cycle -> o_pc = 0x100 instead, count still 1.
- Bad target: redirect 0x42 -> o_pc = 0x100 and a single o_bad_target pulse. Redirect 0x200 -> same response, o_redirect_cnt = 2.
- i_halt_req at o_pc = 0x20 -> o_valid = 0, o_halted = 1, o_pc = 0x20. Redirect/trap while halted -> no change. i_resume -> o_pc = 0, o_valid = 1.
- Saturation: CNT_W = 2, apply 5 redirects -> o_redirect_cnt stops at 3. rst asserted mid-stall -> o_pc = 0, o_valid = 1, counter = 0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter sequencer with redirect, trap, halt and bound handling
// Presents the PC to fetch over valid/ready; all outputs are registered one cycle after the decision.
module pc_sequencer #(
    parameter int          IMEM_WORDS = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC    = 32'h0000_0100,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_valid,
    output logic [31:0]      o_pc,
    input  logic             i_ready,
    input  logic             i_redirect_valid,
    input  logic [31:0]      i_redirect_pc,
    input  logic             i_trap,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic             o_halted,
    output logic             o_bad_target,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] LAST_PC    = 32'((IMEM_WORDS - 1) * 4);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic               r_bad;
    logic               w_bad_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_good_target;

    assign w_good_target = (i_redirect_pc[1:0] == 2'b00) && (i_redirect_pc < IMEM_BYTES);
    // Saturate instead of wrapping so a long-running count never looks small.
    assign w_cnt_inc     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_pc_nxt    = r_pc;
        w_bad_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (i_trap) begin
                    w_pc_nxt    = TRAP_PC;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (i_redirect_valid) begin
                    w_pc_nxt    = w_good_target ? i_redirect_pc : TRAP_PC;
                    w_valid_nxt = 1'b1;
                    w_bad_nxt   = !w_good_target;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (i_halt_req) begin
                    w_state_nxt = ST_HALTED;
                    w_valid_nxt = 1'b0;
                end else if (r_valid && i_ready) begin
                    if (r_pc == LAST_PC) begin
                        w_state_nxt = ST_HALTED;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (i_resume) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = RESET_PC;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = RESET_PC;
                w_valid_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_pc    <= RESET_PC;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_pc    <= w_pc_nxt;
            r_bad   <= w_bad_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_valid        = r_valid;
    assign o_pc           = r_pc;
    assign o_halted       = (r_state == ST_HALTED);
    assign o_bad_target   = r_bad;
    assign o_redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a cycle-level reference model
// Two instances (16-bit and 2-bit counter) share stimulus; the model predicts every cycle's outputs.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ready = 1'b0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        i_trap = 1'b0;
    logic        i_halt_req = 1'b0;
    logic        i_resume = 1'b0;

    logic        o_valid, o_halted, o_bad_target;
    logic [31:0] o_pc;
    logic [15:0] o_redirect_cnt;
    logic        o_valid2, o_halted2, o_bad_target2;
    logic [31:0] o_pc2;
    logic [1:0]  o_redirect_cnt2;

    always #5 clk = ~clk;

    pc_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .o_valid(o_valid), .o_pc(o_pc), .i_ready(i_ready),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc), .i_trap(i_trap),
        .i_halt_req(i_halt_req), .i_resume(i_resume), .o_halted(o_halted),
        .o_bad_target(o_bad_target), .o_redirect_cnt(o_redirect_cnt)
    );

    pc_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .o_valid(o_valid2), .o_pc(o_pc2), .i_ready(i_ready),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc), .i_trap(i_trap),
        .i_halt_req(i_halt_req), .i_resume(i_resume), .o_halted(o_halted2),
        .o_bad_target(o_bad_target2), .o_redirect_cnt(o_redirect_cnt2)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        halted;
        logic        bad;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural state of the sequencer as seen at its outputs.
    bit          m_valid  = 1'b1;
    logic [31:0] m_pc     = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_bad    = 1'b0;
    int unsigned m_cnt    = 0;

    int  hs_count = 0;
    bit  hs_en    = 1'b0;

    always @(posedge clk) if (hs_en && o_valid && i_ready) hs_count++;

    task automatic model_step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit tr, input bit hr, input bit rs);
        bit good;
        good = (rpc % 4 == 0) && (rpc < 32'd512);
        m_bad = 1'b0;
        if (r) begin
            m_valid = 1'b1; m_pc = 32'h0; m_halted = 1'b0; m_cnt = 0;
        end else if (m_halted) begin
            if (rs) begin
                m_halted = 1'b0; m_valid = 1'b1; m_pc = 32'h0;
            end
        end else if (tr) begin
            m_pc = 32'h100; m_valid = 1'b1; m_cnt++;
        end else if (rv) begin
            m_pc = good ? rpc : 32'h100; m_valid = 1'b1; m_bad = !good; m_cnt++;
        end else if (hr) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else if (m_valid && rdy) begin
            if (m_pc == 32'h1FC) begin
                m_halted = 1'b1; m_valid = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc,
                       input bit tr, input bit hr, input bit rs);
        exp_t e;
        @(negedge clk);
        rst = r; i_ready = rdy; i_redirect_valid = rv; i_redirect_pc = rpc;
        i_trap = tr; i_halt_req = hr; i_resume = rs;
        model_step(r, rdy, rv, rpc, tr, hr, rs);
        e.valid  = m_valid;
        e.pc     = m_pc;
        e.halted = m_halted;
        e.bad    = m_bad;
        e.cnt    = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt2   = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, rdy, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to(input logic [31:0] pc);
        for (int k = 0; k < 200 && m_pc != pc; k++) idle(1'b1);
        tests++;
        if (m_pc != pc) begin
            fails++;
            $display("FAIL run_to: model pc=%h required=%h", m_pc, pc);
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle, so each edge retires one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (o_valid !== e.valid || o_pc !== e.pc || o_halted !== e.halted ||
                    o_bad_target !== e.bad || o_redirect_cnt !== e.cnt ||
                    o_valid2 !== e.valid || o_pc2 !== e.pc || o_halted2 !== e.halted ||
                    o_bad_target2 !== e.bad || o_redirect_cnt2 !== e.cnt2) begin
                    fails++;
                    if (fails <= 20)
                        $display("FAIL cycle@%0t: got v=%b pc=%h h=%b bad=%b cnt=%0d cnt2=%0d pc2=%h required v=%b pc=%h h=%b bad=%b cnt=%0d cnt2=%0d",
                                 $time, o_valid, o_pc, o_halted, o_bad_target, o_redirect_cnt,
                                 o_redirect_cnt2, o_pc2, e.valid, e.pc, e.halted, e.bad, e.cnt, e.cnt2);
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        // Straight-line fetch to the end of memory.
        do_reset();
        hs_en = 1'b1;
        for (int k = 0; k < 132; k++) idle(1'b1);
        @(negedge clk);
        hs_en = 1'b0;
        tests++;
        if (hs_count != 128) begin
            fails++;
            $display("FAIL handshake_count: got %0d required 128", hs_count);
        end

        // Stall at 0x10 then release.
        do_reset();
        run_to(32'h10);
        for (int k = 0; k < 5; k++) idle(1'b0);
        idle(1'b1);

        // Redirect during stall, then trap+redirect together.
        do_reset();
        run_to(32'h08);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_to(32'h08);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // Bad targets: misaligned and out of range; redirect to LAST_PC.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h1FC, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Halt, ignored events while halted, resume.
        do_reset();
        run_to(32'h20);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h43, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Counter saturation on the narrow instance, then reset mid-stall.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 32'(k * 16), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) tgt = $urandom_range(0, 127) * 4;
            else if ($urandom_range(0, 1) == 0) tgt = $urandom;
            else tgt = $urandom_range(0, 600);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 24) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
        end

        idle(1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
